mac_acc_ctrl: RTL and testbench
===============================

MAC_ACC_CTRL -- requirements
Module: mac_acc_ctrl

Interface
REQ-001 Parameter NUM_MAC, default 8: number of parallel MAC lanes.
REQ-002 Parameter NUM_COEFF, default 256: accepted a-coefficient beats per pass.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock, sole clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  begin a pass; sampled only in IDLE.
REQ-007 secret_in  input  NUM_MAC*4  initial secret lanes, sign-magnitude (bit3 sign, bits2:0 magnitude); captured on start.
REQ-008 a_valid  input  1  a_coeff_in valid.
REQ-009 a_coeff_in  input  13  incoming public coefficient.
REQ-010 a_ready  output  1  block accepts a beat.
REQ-011 mult_a_coeff  output  13  coefficient to the parallel multiplier.
REQ-012 mult_secret  output  NUM_MAC*4  current secret lanes to the multiplier.
REQ-013 mult_acc  output  NUM_MAC*16  accumulator lanes to the multiplier.
REQ-014 mult_result  input  NUM_MAC*16  combinational multiplier result, same cycle.
REQ-015 busy  output  1  high in RUN.
REQ-016 done  output  1  one-cycle pulse at end of pass.
REQ-017 acc_result  output  NUM_MAC*16  final accumulators; held until next start.

Function
REQ-018 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-019 IDLE: a_ready=0, busy=0; start=1 -> clear all accumulators to 0, load secret register from secret_in, clear beat counter, go RUN.
REQ-020 RUN: a_ready=1, busy=1; a beat is accepted when a_valid & a_ready.
REQ-021 mult_a_coeff = a_coeff_in (combinational pass-through); mult_secret = secret register; lane i of mult_acc = {3'b000, acc[i][12:0]}.
REQ-022 On an accepted beat, acc[i] <= mult_result[i*16+12 : i*16] (arithmetic mod 2^13, bits 15:13 discarded), same clock edge.
REQ-023 On an accepted beat, secret register rotates negacyclically: lane i <= lane i-1 for i>=1; lane 0 <= lane NUM_MAC-1 with bit3 inverted.
REQ-024 No accepted beat -> accumulators, secret register, and counter hold (bubbles allowed any number of cycles).
REQ-025 Beat counter width ceil(log2(NUM_COEFF)); increments per accepted beat; accepted beat with counter == NUM_COEFF-1 -> go DONE, counter wraps to 0.
REQ-026 DONE: lasts exactly one cycle, done=1, a_ready=0, busy=0; then IDLE.
REQ-027 start in RUN or DONE is ignored; a_valid in IDLE or DONE is ignored, with no state change.
REQ-028 acc_result lane i = {3'b000, acc[i][12:0]}; it is valid from the DONE cycle until the next accepted start.
REQ-029 Latency: the last beat accepted on edge k -> done high in cycle k+1, next IDLE at k+2.

Reset
REQ-030 rst=1 on any edge: state IDLE, accumulators 0, secret register 0, counter 0; done=0, busy=0, a_ready=0, acc_result=0.
REQ-031 rst asserted mid-pass aborts the pass with no done pulse; rst has priority over start and a_valid in the same cycle.

Verification
REQ-032 NUM_MAC=8, NUM_COEFF=4, secret all lanes 4'b0001, a_coeff=1 every beat, reference multiplier -> done 1 cycle after 4th beat; every acc_result lane = 4.
REQ-033 secret lane7=4'b0010, other lanes 0, one beat -> mult_secret lane0 = 4'b1010 on next cycle; lane7 = 0.
REQ-034 a_valid toggled 1/0 every cycle, NUM_COEFF=4 -> exactly 4 beats counted; done in cycle after 4th accepted beat; accumulators hold during bubbles.
REQ-035 mult_result lane forced to 16'hFFFF on a beat -> acc lane = 13'h1FFF; mult_acc lane = 16'h1FFF next cycle.
REQ-036 rst asserted after 2 of 4 beats -> IDLE next cycle, done never pulses, acc_result=0; a new start then runs a full 4-beat pass.
REQ-037 start held high through a pass -> start ignored in RUN; a second pass begins in the first IDLE cycle after DONE.

Source files
------------

// File: rtl/mac_acc_ctrl.sv
// Pass controller for a parallel multiply-accumulate array.
// Holds NUM_MAC 13-bit accumulators and a sign-magnitude secret register.
// Each accepted coefficient beat loads the external multiplier's result
// into the accumulators and rotates the secret negacyclically.
// After NUM_COEFF beats the controller pulses done for one cycle.
module mac_acc_ctrl #(
  parameter int unsigned NUM_MAC   = 8,
  parameter int unsigned NUM_COEFF = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NUM_MAC*4-1:0]    secret_in,
  input  logic                    a_valid,
  input  logic [12:0]             a_coeff_in,
  output logic                    a_ready,
  output logic [12:0]             mult_a_coeff,
  output logic [NUM_MAC*4-1:0]    mult_secret,
  output logic [NUM_MAC*16-1:0]   mult_acc,
  input  logic [NUM_MAC*16-1:0]   mult_result,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_MAC*16-1:0]   acc_result
);

  localparam int unsigned CW = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_COEFF - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [12:0]     acc    [NUM_MAC];
  logic [3:0]      secret [NUM_MAC];
  logic [CW-1:0]   cnt;
  logic            beat;
  logic [NUM_MAC*3-1:0] unused_hi;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (beat && (cnt == LAST)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded handshake and status outputs
  always_comb begin
    a_ready      = (state == RUN);
    busy         = (state == RUN);
    done         = (state == DONE);
    beat         = a_valid & (state == RUN);
    mult_a_coeff = a_coeff_in;
  end

  // Accumulator, secret rotation and beat counter
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_MAC; i++) begin
        acc[i]    <= '0;
        secret[i] <= '0;
      end
      cnt <= '0;
    end else if ((state == IDLE) && start) begin
      for (int unsigned i = 0; i < NUM_MAC; i++) begin
        acc[i]    <= '0;
        secret[i] <= secret_in[i*4 +: 4];
      end
      cnt <= '0;
    end else if (beat) begin
      for (int unsigned i = 0; i < NUM_MAC; i++) begin
        acc[i] <= mult_result[i*16 +: 13];
      end
      // Negacyclic shift: the lane wrapping to position 0 flips its sign bit
      secret[0] <= {~secret[NUM_MAC-1][3], secret[NUM_MAC-1][2:0]};
      for (int unsigned i = 1; i < NUM_MAC; i++) begin
        secret[i] <= secret[i-1];
      end
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  // Lane packing; accumulators persist after DONE so acc_result holds until next start
  always_comb begin
    mult_secret = '0;
    mult_acc    = '0;
    acc_result  = '0;
    unused_hi   = '0;
    for (int unsigned i = 0; i < NUM_MAC; i++) begin
      mult_secret[i*4 +: 4]   = secret[i];
      mult_acc[i*16 +: 16]    = {3'b000, acc[i]};
      acc_result[i*16 +: 16]  = {3'b000, acc[i]};
      // Upper product bits are intentionally dropped: accumulation is mod 2^13
      unused_hi[i*3 +: 3]     = mult_result[i*16+13 +: 3];
    end
  end

endmodule

// File: tb/tb_mac_acc_ctrl.sv
// Self-checking bench for mac_acc_ctrl (8 lanes, 4 beats per pass).
module tb_mac_acc_ctrl;

  localparam int NM = 8;
  localparam int NC = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [NM*4-1:0]   secret_in;
  logic              a_valid;
  logic [12:0]       a_coeff_in;
  logic              a_ready;
  logic [12:0]       mult_a_coeff;
  logic [NM*4-1:0]   mult_secret;
  logic [NM*16-1:0]  mult_acc;
  logic [NM*16-1:0]  mult_result;
  logic              busy;
  logic              done;
  logic [NM*16-1:0]  acc_result;

  int tests = 0;
  int fails = 0;
  int force_lane = -1;
  int done_seen = 0;
  bit model_live = 1'b0;

  always #5 clk = ~clk;

  mac_acc_ctrl #(.NUM_MAC(NM), .NUM_COEFF(NC)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .secret_in    (secret_in),
    .a_valid      (a_valid),
    .a_coeff_in   (a_coeff_in),
    .a_ready      (a_ready),
    .mult_a_coeff (mult_a_coeff),
    .mult_secret  (mult_secret),
    .mult_acc     (mult_acc),
    .mult_result  (mult_result),
    .busy         (busy),
    .done         (done),
    .acc_result   (acc_result)
  );

  // Reference multiplier: acc + coeff * |secret| per lane, one lane optionally forced to all ones
  always_comb begin
    mult_result = '0;
    for (int i = 0; i < NM; i++) begin
      if (i == force_lane)
        mult_result[i*16 +: 16] = 16'hFFFF;
      else
        mult_result[i*16 +: 16] = mult_acc[i*16 +: 16]
                                + 16'(mult_a_coeff) * 16'(mult_secret[i*4 +: 3]);
    end
  end

  // Behavioural model: pass phase, accumulators as integers mod 2^13, secret lanes
  typedef enum {M_IDLE, M_RUN, M_DONE} mphase_t;
  mphase_t     m_phase;
  logic [12:0] m_acc [NM];
  logic [3:0]  m_sec [NM];
  int          m_beats;

  always @(posedge clk) begin
    model_live <= 1'b1;
    if (rst) begin
      m_phase <= M_IDLE;
      m_beats <= 0;
      for (int i = 0; i < NM; i++) begin
        m_acc[i] <= '0;
        m_sec[i] <= '0;
      end
    end else begin
      case (m_phase)
        M_IDLE: if (start) begin
          m_phase <= M_RUN;
          m_beats <= 0;
          for (int i = 0; i < NM; i++) begin
            m_acc[i] <= '0;
            m_sec[i] <= secret_in[i*4 +: 4];
          end
        end
        M_RUN: if (a_valid) begin
          for (int i = 0; i < NM; i++)
            m_acc[i] <= (i == force_lane) ? 13'h1FFF
                      : 13'(m_acc[i] + a_coeff_in * 13'(m_sec[i][2:0]));
          m_sec[0] <= m_sec[NM-1] ^ 4'b1000;
          for (int i = 1; i < NM; i++) m_sec[i] <= m_sec[i-1];
          if (m_beats == NC - 1) begin
            m_beats <= 0;
            m_phase <= M_DONE;
          end else begin
            m_beats <= m_beats + 1;
          end
        end
        default: m_phase <= M_IDLE;
      endcase
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare process: DUT outputs against the model every cycle
  always @(negedge clk) begin
    logic [NM*4-1:0]  e_sec;
    logic [NM*16-1:0] e_acc;
    if (model_live) begin
      for (int i = 0; i < NM; i++) begin
        e_sec[i*4 +: 4]   = m_sec[i];
        e_acc[i*16 +: 16] = {3'b000, m_acc[i]};
      end
      chk("a_ready",      a_ready,      m_phase == M_RUN);
      chk("busy",         busy,         m_phase == M_RUN);
      chk("done",         done,         m_phase == M_DONE);
      chk("mult_a_coeff", mult_a_coeff, a_coeff_in);
      chk("mult_secret",  mult_secret,  e_sec);
      chk("mult_acc",     mult_acc,     e_acc);
      chk("acc_result",   acc_result,   e_acc);
      if (done) done_seen++;
    end
  end

  function automatic logic [15:0] lane16(input logic [NM*16-1:0] v, input int i);
    return v[i*16 +: 16];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass(input logic [NM*4-1:0] s);
    secret_in = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input bit v, input logic [12:0] c);
    a_valid = v;
    a_coeff_in = c;
    tick();
    a_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; a_valid = 1'b0; a_coeff_in = '0; secret_in = '0;
    tick(); tick();
    @(negedge clk);
    chk("reset acc_result", acc_result, '0);
    chk("reset busy", busy, 1'b0);
    rst = 1'b0;
    tick();

    // Basic pass: all lanes 0001, coeff 1 each beat
    start_pass({NM{4'b0001}});
    repeat (NC) beat(1'b1, 13'd1);
    @(negedge clk);
    chk("basic done", done, 1'b1);
    tick();
    for (int i = 0; i < NM; i++) chk("basic lane", lane16(acc_result, i), 16'd4);

    // Negacyclic wrap of lane 7 into lane 0
    start_pass({4'b0010, 28'h0});
    beat(1'b1, 13'd3);
    @(negedge clk);
    chk("rot lane0", mult_secret[3:0], 4'b1010);
    chk("rot lane7", mult_secret[31:28], 4'b0000);
    repeat (NC - 1) beat(1'b1, 13'd3);
    tick();

    // Bubbles between beats
    start_pass(32'h9A3F_0C71);
    beat(1'b1, 13'd5); beat(1'b0, 13'd5);
    beat(1'b1, 13'd7); beat(1'b0, 13'd7);
    beat(1'b1, 13'd2); beat(1'b0, 13'd0);
    @(negedge clk);
    chk("bubble busy after 3", busy, 1'b1);
    beat(1'b1, 13'd9);
    @(negedge clk);
    chk("bubble done", done, 1'b1);
    tick();
    chk("bubble lane0", lane16(acc_result, 0), 16'd43);
    chk("bubble lane4", lane16(acc_result, 4), 16'd106);

    // Upper multiplier bits are discarded
    start_pass({NM{4'b0011}});
    beat(1'b1, 13'd2);
    force_lane = 3;
    beat(1'b1, 13'd2);
    force_lane = -1;
    @(negedge clk);
    chk("forced mult_acc", lane16(mult_acc, 3), 16'h1FFF);
    beat(1'b1, 13'd2);
    @(negedge clk);
    chk("wrap mult_acc", lane16(mult_acc, 3), 16'h0005);
    beat(1'b1, 13'd2);
    tick();

    // Reset mid-pass aborts without done
    start_pass({NM{4'b0001}});
    beat(1'b1, 13'd4); beat(1'b1, 13'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort busy", busy, 1'b0);
    chk("abort acc_result", acc_result, '0);
    chk("abort done", done, 1'b0);
    rst = 1'b1; start = 1'b1; a_valid = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; a_valid = 1'b0;
    @(negedge clk);
    chk("rst priority busy", busy, 1'b0);
    start_pass({NM{4'b0001}});
    beat(1'b1, 13'd1); beat(1'b1, 13'd2); beat(1'b1, 13'd3); beat(1'b1, 13'd4);
    @(negedge clk);
    chk("restart done", done, 1'b1);
    tick();
    for (int i = 0; i < NM; i++) chk("restart lane", lane16(acc_result, i), 16'd10);
    chk("done count", done_seen, 5);

    // start held high across a pass, a_valid held through DONE and IDLE
    secret_in = {NM{4'b0001}};
    start = 1'b1; a_valid = 1'b1; a_coeff_in = 13'd1;
    tick();
    repeat (NC) tick();
    @(negedge clk);
    chk("held done", done, 1'b1);
    secret_in = {NM{4'b0010}};
    tick();
    @(negedge clk);
    chk("held idle busy", busy, 1'b0);
    chk("held idle lane0", lane16(acc_result, 0), 16'd4);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("second pass busy", busy, 1'b1);
    chk("second pass secret", mult_secret, {NM{4'b0010}});
    repeat (NC) tick();
    a_valid = 1'b0;
    @(negedge clk);
    chk("second done", done, 1'b1);
    tick();
    for (int i = 0; i < NM; i++) chk("second lane", lane16(acc_result, i), 16'd8);
    chk("final done count", done_seen, 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
